piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 p_in  input  WIDTH  parallel word to serialize.
REQ-006 p_valid  input  1  p_in holds a word offered for transfer.
REQ-007 p_ready  output  1  block can accept a word this cycle.
REQ-008 s_out  output  1  serial data bit; feeds the downstream SISO shift register's s_in.
REQ-009 s_valid  output  1  s_out carries a valid bit this cycle.
REQ-010 s_last  output  1  s_out is the final bit of the current word.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word being emitted).
REQ-012 The block SHALL hold a WIDTH-bit shift register and a bit counter of width clog2(WIDTH), counting 0..WIDTH-1.
REQ-013 p_ready SHALL be 1 when state = IDLE, or when state = SHIFT and counter = WIDTH-1; 0 otherwise; 0 whenever rst = 1.
REQ-014 p_ready SHALL depend only on registered state and rst, never on p_valid.
REQ-015 Transfer SHALL occur on a rising edge where p_valid = 1 and p_ready = 1: p_in is loaded, counter cleared, state becomes SHIFT.
REQ-016 Latency: first bit SHALL appear on s_out with s_valid = 1 in the cycle after the transfer edge.
REQ-017 In SHIFT, one bit SHALL be emitted per cycle with no gaps: bit WIDTH-1 down to 0 if MSB_FIRST = 1, bit 0 up to WIDTH-1 otherwise.
REQ-018 s_last SHALL be 1 only while s_valid = 1 and counter = WIDTH-1.
REQ-019 On the last-bit cycle with p_valid = 1: next word SHALL be loaded and its first bit emitted the following cycle; s_valid stays 1 (back-to-back, zero bubble).
REQ-020 On the last-bit cycle with p_valid = 0: state SHALL return to IDLE; s_valid = 0 the following cycle.
REQ-021 When s_valid = 0, s_out and s_last SHALL be 0.
REQ-022 Changes on p_in or p_valid while p_ready = 0 SHALL not affect the word being emitted.
REQ-023 There is no downstream back-pressure; bits SHALL be emitted unconditionally once loaded.

Reset
REQ-024 With rst = 1 at a rising edge: state <= IDLE, counter <= 0, shift register <= 0.
REQ-025 Outputs in the cycle after a reset edge: s_valid = 0, s_out = 0, s_last = 0; p_ready = 0 while rst = 1, 1 in the first cycle rst = 0.
REQ-026 Reset mid-word SHALL abandon the word; no remaining bits are emitted; rst SHALL take priority over a simultaneous transfer.

Verification (WIDTH = 4 unless stated)
REQ-027 Reset: rst = 1 for 2 cycles -> s_valid = 0, s_out = 0, s_last = 0, p_ready = 0 throughout; p_ready = 1 in the first cycle after rst drops.
REQ-028 Single word: p_in = 4'b1011, p_valid pulsed 1 cycle -> s_out = 1,0,1,1 on 4 consecutive cycles, s_valid = 1 on all 4, s_last = 1 on the 4th only; p_ready = 0 on bits 1-3 and 1 on bit 4; s_valid = 0 afterwards.
REQ-029 Back-to-back: 4'b1011 then 4'b0110 with p_valid held 1 -> 8 contiguous bits 1,0,1,1,0,1,1,0; s_valid never drops; s_last = 1 on bits 4 and 8.
REQ-030 Input stability: load 4'b1011, then drive p_in = 4'b0000, p_valid = 1 during bits 1-3 -> emitted bits remain 1,0,1,1; 4'b0000 is loaded at the bit-4 edge.
REQ-031 Mid-word reset: load 4'b1111, assert rst for 1 cycle during bit 2 -> s_valid = 0 the next cycle with no further 1s; a following load of 4'b1001 emits 1,0,0,1 cleanly.
REQ-032 LSB-first: MSB_FIRST = 0, p_in = 4'b1011 -> s_out = 1,1,0,1, s_last on the 4th bit.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with valid/ready load and zero-bubble word chaining
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             at_last;
    logic             load;
    logic [WIDTH-1:0] sreg_shifted;

    assign at_last = (state == SHIFT) && (cnt == CNT_LAST);

    // Ready is a function of registered state and rst only, so it never loops back through p_valid.
    assign p_ready = !rst && ((state == IDLE) || at_last);
    assign load    = p_valid && p_ready;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
            assign s_out        = (state == SHIFT) && sreg[WIDTH-1];
        end else begin : g_lsb
            assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
            assign s_out        = (state == SHIFT) && sreg[0];
        end
    endgenerate

    assign s_valid = (state == SHIFT);
    assign s_last  = at_last;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sreg_nxt  = p_in;
                end
            end
            SHIFT: begin
                if (load) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sreg_nxt  = p_in;
                end else if (at_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sreg_nxt  = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    sreg_nxt  = sreg_shifted;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                sreg_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] p_in = '0;
    logic         p_valid = 1'b0;

    logic pr_m, so_m, sv_m, sl_m;
    logic pr_l, so_l, sv_l, sl_l;

    int checks = 0;
    int errors = 0;

    // Expected bit stream: {msb-first bit, lsb-first bit, last flag}
    logic [2:0] sbq[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid),
        .p_ready(pr_m), .s_out(so_m), .s_valid(sv_m), .s_last(sl_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid),
        .p_ready(pr_l), .s_out(so_l), .s_valid(sv_l), .s_last(sl_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs at negedge against the scoreboard, update it at posedge.
    task automatic cycle();
        logic       exp_rdy;
        logic       exp_sv;
        logic [2:0] head;
        @(negedge clk);
        exp_rdy = !rst && (sbq.size() <= 1);
        exp_sv  = (sbq.size() > 0);
        head    = exp_sv ? sbq[0] : 3'b000;
        chk("p_ready_m", pr_m, exp_rdy);
        chk("p_ready_l", pr_l, exp_rdy);
        chk("s_valid_m", sv_m, exp_sv);
        chk("s_valid_l", sv_l, exp_sv);
        chk("s_out_m",   so_m, head[2]);
        chk("s_out_l",   so_l, head[1]);
        chk("s_last_m",  sl_m, head[0]);
        chk("s_last_l",  sl_l, head[0]);
        @(posedge clk);
        if (rst) begin
            sbq.delete();
        end else begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            if (p_valid && exp_rdy) begin
                for (int k = 0; k < W; k++)
                    sbq.push_back({p_in[W-1-k], p_in[k], (k == W-1)});
            end
        end
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic         pv;
        logic [W-1:0] pin;
        logic         e_sv;
        logic         e_som;
        logic         e_sol;
        logic         e_sl;
        logic         e_pr;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[7] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Settle state with one reset edge before any comparison.
        @(posedge clk);
        #1;

        // Reset, single word MSB/LSB first
        for (int i = 0; i < 8; i++) begin
            rst     = vt[i].rst;
            p_valid = vt[i].pv;
            p_in    = vt[i].pin;
            @(negedge clk);
            chk("vec_s_valid", sv_m, vt[i].e_sv);
            chk("vec_s_out_m", so_m, vt[i].e_som);
            chk("vec_s_out_l", so_l, vt[i].e_sol);
            chk("vec_s_last",  sl_m, vt[i].e_sl);
            chk("vec_p_ready", pr_m, vt[i].e_pr);
            @(posedge clk);
            #1;
        end
        sbq.delete();
        cycle();

        // Back-to-back: 1011 then 0110, p_valid held high
        p_valid = 1'b1; p_in = 4'b1011;
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) p_in = 4'b0110;
            cycle();
        end
        p_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // Input stability: garbage offered while busy, loaded only at the last bit
        p_valid = 1'b1; p_in = 4'b1011;
        cycle();
        p_in = 4'b0000;
        for (int i = 0; i < 4; i++) cycle();
        p_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // Mid-word reset during bit 2, then clean reload
        p_valid = 1'b1; p_in = 4'b1111;
        cycle();
        p_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        p_valid = 1'b1; p_in = 4'b1001;
        cycle();
        p_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // Reset coinciding with an offered word: reset wins
        rst = 1'b1; p_valid = 1'b1; p_in = 4'b1111;
        cycle();
        rst = 1'b0; p_valid = 1'b0;
        for (int i = 0; i < 2; i++) cycle();

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            p_valid = ($urandom_range(0, 3) != 0);
            p_in    = W'($urandom);
            rst     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0; p_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending bits expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
